nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl_if.sv | 64 ++++++
 rtl/nibble_serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester and shared nibble-adder signals for nibble_serial_add_ctrl.
// The slave modport is the sequencer's view; the master modport is the
// requester plus the external 4-bit adder.
// Optional macro SUB_EN adds the `sub` request bit.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
`ifdef SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_ci;
    logic [3:0]   add_s;
    logic         add_co;

    modport slave (
`ifdef SUB_EN
        input  sub,
`endif
        input  start,
        input  a,
        input  b,
        input  ci,
        output busy,
        output done,
        output s,
        output co,
        output add_a,
        output add_b,
        output add_ci,
        input  add_s,
        input  add_co
    );

    modport master (
`ifdef SUB_EN
        output sub,
`endif
        output start,
        output a,
        output b,
        output ci,
        input  busy,
        input  done,
        input  s,
        input  co,
        input  add_a,
        input  add_b,
        input  add_ci,
        output add_s,
        output add_co
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built by time-multiplexing one external 4-bit adder,
// least-significant nibble first, carry held in a register between passes.
// Optional macro SUB_EN: adds `sub` (a - b via inverted b and forced carry-in).
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     sum_r;
    logic [W-1:0]     s_r;
    logic             co_r;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] offset;
    logic             accept;
    logic             last;
    logic [W-1:0]     b_in;
    logic             carry_in;

    // Replace nibble i of word with nib.
    function automatic logic [W-1:0] merge_nibble(input logic [W-1:0]     word,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [3:0]       nib);
        logic [W-1:0] r;
        r = word;
        r[{i, 2'b00} +: 4] = nib;
        return r;
    endfunction

    // New operands are taken in IDLE and also in DONE (back-to-back);
    // a start seen in RUN is dropped.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == LAST_IDX);
    assign offset = {idx, 2'b00};

`ifdef SUB_EN
    // Subtraction is a + ~b + 1; the requested carry-in is ignored then.
    always_comb begin
        b_in     = bus.sub ? ~bus.b : bus.b;
        carry_in = bus.sub ? 1'b1 : bus.ci;
    end
`else
    // Plain addition: operands and carry-in pass straight through.
    always_comb begin
        b_in     = bus.b;
        carry_in = bus.ci;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-pass nibble accumulation and final result update.
    // s/co only change on the last pass so the requester never sees partials.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum_r <= '0;
            s_r   <= '0;
            co_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= b_in;
            carry <= carry_in;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r <= merge_nibble(sum_r, idx, bus.add_s);
            carry <= bus.add_co;
            idx   <= idx + 1'b1;
            if (last) begin
                s_r  <= merge_nibble(sum_r, idx, bus.add_s);
                co_r <= bus.add_co;
            end
        end
    end

    // Adder inputs are only driven while a pass is in progress.
    assign bus.add_a  = (state == RUN) ? a_r[offset +: 4] : 4'h0;
    assign bus.add_b  = (state == RUN) ? b_r[offset +: 4] : 4'h0;
    assign bus.add_ci = (state == RUN) ? carry : 1'b0;

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.s    = s_r;
    assign bus.co   = co_r;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl: behavioural nibble adder, table of
// addition vectors, scoreboard of expected results popped on each done pulse,
// and hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_nibble_serial_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // External 4-bit adder, purely combinational.
    assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_ci};

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Result monitor: every done pulse must match the oldest pending result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("result_s", 64'(bus.s), 64'(e.s));
                check("result_co", 64'(bus.co), 64'(e.co));
            end
        end
    end

    // Drive a start for one edge and record the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic eco);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.ci    = ci;
        e.s       = es;
        e.co      = eco;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; checks busy and held outputs
    // each RUN cycle and the edge count to done.
    task automatic wait_done(input string name);
        int           edges;
        bit           seen;
        logic [W-1:0] s_hold;
        logic         co_hold;
        edges   = 0;
        seen    = 0;
        s_hold  = bus.s;
        co_hold = bus.co;
        while (!seen && edges < 4 * NIBBLES + 8) begin
            check({name, "_busy"}, 64'(bus.busy), 64'd1);
            check({name, "_s_held"}, 64'(bus.s), 64'(s_hold));
            check({name, "_co_held"}, 64'(bus.co), 64'(co_hold));
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) seen = 1;
        end
        check({name, "_latency"}, 64'(edges), 64'(NIBBLES));
        check({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic [W-1:0] es, input logic eco);
        @(negedge clk);
        issue(a, b, ci, es, eco);
        wait_done(name);
        @(posedge clk);
        #1;
        check({name, "_done_width"}, 64'(bus.done), 64'd0);
        check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[8];
        int   d0;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
        vecs[7] = '{16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
`ifdef SUB_EN
        bus.sub   = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_s", 64'(bus.s), 64'd0);
        check("rst_co", 64'(bus.co), 64'd0);
        check("rst_add_a", 64'(bus.add_a), 64'd0);
        check("rst_add_ci", 64'(bus.add_ci), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Table-driven additions
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);
        end

        // start during RUN is ignored
        @(negedge clk);
        d0 = n_done;
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ign_done_on_time", 64'(bus.done), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("ign_done_count", 64'(n_done - d0), 64'd1);
        check("ign_s", 64'(bus.s), 64'h0002);
        check("ign_co", 64'(bus.co), 64'd0);

        // Back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        wait_done("b2b_first");
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        wait_done("b2b_second");
        @(posedge clk);
        #1;
        check("b2b_done_width", 64'(bus.done), 64'd0);

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        d0 = n_done;
        bus.start = 1'b1;
        bus.a     = 16'h5555;
        bus.b     = 16'h1111;
        bus.ci    = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_s", 64'(bus.s), 64'd0);
        check("mid_rst_co", 64'(bus.co), 64'd0);
        check("mid_rst_add_b", 64'(bus.add_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(n_done - d0), 64'd0);
        check("mid_rst_s_stays", 64'(bus.s), 64'd0);
        run_vec("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

`ifdef SUB_EN
        // Subtraction: ci is ignored when sub=1
        bus.sub = 1'b1;
        run_vec("sub_neg", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_vec("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
        bus.sub = 1'b0;
        run_vec("sub_off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
